bip_control: RTL and testbench

Multi-cycle control unit for the BIP accumulator processor. It fetches 16-bit instructions from program memory, decodes the 5-bit opcode, and drives everything downstream of decode: the arithmetic unit's `Op` select, the accumulator/operand muxes, and the accumulator and data-memory strobes. It sits between program memory and the datapath. It generates the signals the arithmetic unit only consumes, and it retires one instruction every 3 cycles until `HLT`.

---
 rtl/bip_control_if.sv | 33 +++
 rtl/bip_control.sv | 157 +++++++++++++++
 tb/tb_bip_control.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bip_control_if.sv
// Bundle of signals between the BIP control unit and the blocks it talks to:
// program memory on one side and the accumulator datapath / data memory on
// the other. The control unit is the master.
interface bip_control_if #(
  parameter int PC_W = 11,
  parameter int msb  = 10
);
  logic            start;
  logic [15:0]     instr;
  logic [PC_W-1:0] pc_addr;
  logic [msb:0]    operand;
  logic            op;
  logic [1:0]      sel_a;
  logic            sel_b;
  logic            wr_acc;
  logic            rd_ram;
  logic            wr_ram;
  logic            busy;
  logic            halted;
  logic [15:0]     instr_count;

  modport master (
    input  start, instr,
    output pc_addr, operand, op, sel_a, sel_b,
           wr_acc, rd_ram, wr_ram, busy, halted, instr_count
  );

  modport slave (
    output start, instr,
    input  pc_addr, operand, op, sel_a, sel_b,
           wr_acc, rd_ram, wr_ram, busy, halted, instr_count
  );
endinterface

// File: rtl/bip_control.sv
// BIP accumulator processor control unit. Fetches one 16-bit instruction,
// decodes its 5-bit opcode and issues the datapath strobes, retiring one
// instruction every three cycles (FETCH, DECODE, EXEC) until HLT.
// Strobes come only from the registered state and IR, so they never follow
// glitches on the program-memory data bus.
module bip_control #(
  parameter int PC_W = 11,
  parameter int msb  = 10
) (
  input  logic          clk,
  input  logic          reset,
  bip_control_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  state_t          state;
  state_t          next_state;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [15:0]     count;
  logic [4:0]      opcode;

  logic            op;
  logic [1:0]      sel_a;
  logic            sel_b;
  logic            wr_acc;
  logic            rd_ram;
  logic            wr_ram;

  assign opcode = ir[15:11];

  // State register; reset returns to IDLE at once, even mid-instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // IR captures program memory on entry to DECODE; PC and retire count advance as EXEC ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= '0;
      ir    <= '0;
      count <= '0;
    end else begin
      if (state == FETCH) begin
        ir <= bus.instr;
      end
      if (state == EXEC) begin
        if (count != 16'hFFFF) begin
          count <= count + 16'd1;
        end
        if (opcode != OP_HLT) begin
          pc <= pc + PC_W'(1);
        end
      end
    end
  end

  // Next-state and strobe decode; every output idles at its default unless a state/opcode asks otherwise
  always_comb begin
    next_state = state;
    op         = 1'b0;
    sel_a      = 2'b00;
    sel_b      = 1'b0;
    wr_acc     = 1'b0;
    rd_ram     = 1'b0;
    wr_ram     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          next_state = FETCH;
        end
      end
      FETCH: begin
        next_state = DECODE;
      end
      DECODE: begin
        next_state = EXEC;
        if (opcode == OP_LD || opcode == OP_ADD || opcode == OP_SUB) begin
          rd_ram = 1'b1;
        end
      end
      EXEC: begin
        next_state = (opcode == OP_HLT) ? HALT : FETCH;
        case (opcode)
          OP_STO: begin
            wr_ram = 1'b1;
          end
          OP_LD: begin
            wr_acc = 1'b1;
            sel_a  = 2'b10;
          end
          OP_LDI: begin
            wr_acc = 1'b1;
            sel_a  = 2'b01;
          end
          OP_ADD: begin
            wr_acc = 1'b1;
            op     = 1'b1;
          end
          OP_ADDI: begin
            wr_acc = 1'b1;
            op     = 1'b1;
            sel_b  = 1'b1;
          end
          OP_SUB: begin
            wr_acc = 1'b1;
          end
          OP_SUBI: begin
            wr_acc = 1'b1;
            sel_b  = 1'b1;
          end
          default: begin
          end
        endcase
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign bus.pc_addr     = pc;
  assign bus.operand     = (msb + 1)'(ir[10:0]);
  assign bus.op          = op;
  assign bus.sel_a       = sel_a;
  assign bus.sel_b       = sel_b;
  assign bus.wr_acc      = wr_acc;
  assign bus.rd_ram      = rd_ram;
  assign bus.wr_ram      = wr_ram;
  assign bus.busy        = (state == FETCH) || (state == DECODE) || (state == EXEC);
  assign bus.halted      = (state == HALT);
  assign bus.instr_count = count;

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control. Two instances share clock, reset and
// start: a default one (PC_W = 11) and a narrow one (PC_W = 3) for PC wrap.
// Programs run from a shared array; the expected outputs for every cycle are
// derived from the instruction sequence (instruction index and phase within
// its three cycles), not from the design's internals.
module tb_bip_control;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic useB;

  logic [15:0] prog [0:2047];

  always #5 clk = ~clk;

  bip_control_if #(.PC_W(11), .msb(10)) busA ();
  bip_control_if #(.PC_W(3),  .msb(10)) busB ();

  assign busA.start = start;
  assign busB.start = start;
  assign busA.instr = prog[busA.pc_addr];
  assign busB.instr = prog[11'(busB.pc_addr)];

  bip_control #(.PC_W(11), .msb(10)) dutA (.clk(clk), .reset(reset), .bus(busA));
  bip_control #(.PC_W(3),  .msb(10)) dutB (.clk(clk), .reset(reset), .bus(busB));

  int checkCount = 0;
  int passCount  = 0;

  logic [8:0]  obsCtl;
  logic [15:0] obsPc;
  logic [15:0] obsCnt;
  logic [10:0] obsOpnd;

  // Observe whichever instance the current test targets
  always_comb begin
    if (useB) begin
      obsCtl  = {busB.op, busB.sel_a, busB.sel_b, busB.wr_acc, busB.rd_ram,
                 busB.wr_ram, busB.busy, busB.halted};
      obsPc   = 16'(busB.pc_addr);
      obsCnt  = busB.instr_count;
      obsOpnd = busB.operand;
    end else begin
      obsCtl  = {busA.op, busA.sel_a, busA.sel_b, busA.wr_acc, busA.rd_ram,
                 busA.wr_ram, busA.busy, busA.halted};
      obsPc   = 16'(busA.pc_addr);
      obsCnt  = busA.instr_count;
      obsOpnd = busA.operand;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Expected {op, sel_a, sel_b, wr_acc, rd_ram, wr_ram, busy, halted}
  // phase: 0 idle/reset, 1 fetch, 2 decode, 3 exec, 4 halted
  function automatic logic [8:0] expCtl(input int phase, input logic [4:0] opc);
    logic o = 1'b0;
    logic [1:0] sa = 2'b00;
    logic sb = 1'b0, wa = 1'b0, rr = 1'b0, wr = 1'b0, bz = 1'b0, hl = 1'b0;
    case (phase)
      1: bz = 1'b1;
      2: begin
        bz = 1'b1;
        rr = (opc == 5'd2) || (opc == 5'd4) || (opc == 5'd6);
      end
      3: begin
        bz = 1'b1;
        case (opc)
          5'd1: wr = 1'b1;
          5'd2: begin wa = 1'b1; sa = 2'b10; end
          5'd3: begin wa = 1'b1; sa = 2'b01; end
          5'd4: begin wa = 1'b1; o = 1'b1; end
          5'd5: begin wa = 1'b1; o = 1'b1; sb = 1'b1; end
          5'd6: wa = 1'b1;
          5'd7: begin wa = 1'b1; sb = 1'b1; end
          default: ;
        endcase
      end
      4: hl = 1'b1;
      default: ;
    endcase
    return {o, sa, sb, wa, rr, wr, bz, hl};
  endfunction

  task automatic checkState(input string tag, input int phase, input logic [4:0] opc,
                            input int pcExp, input int cntExp,
                            input bit withOpnd, input logic [10:0] opndExp);
    checkOutput({tag, "/ctl"}, 32'(obsCtl), 32'(expCtl(phase, opc)));
    checkOutput({tag, "/pc"}, 32'(obsPc), 32'(pcExp));
    checkOutput({tag, "/cnt"}, 32'(obsCnt), 32'(cntExp));
    if (withOpnd) checkOutput({tag, "/opnd"}, 32'(obsOpnd), 32'(opndExp));
  endtask

  task automatic doReset(input string name);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkState({name, "/rst"}, 0, 5'd0, 0, 0, 1'b1, 11'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkState({name, "/idle"}, 0, 5'd0, 0, 0, 1'b0, 11'd0);
  endtask

  // Reset, start, then step the program instruction by instruction
  task automatic applyStimulus(input bit dutB, input int pcw, input int maxInstr,
                               input string name);
    int pcM = 0;
    int cntM = 0;
    int n = 0;
    bit done = 1'b0;
    int mask = (1 << pcw) - 1;
    logic [15:0] word;
    logic [4:0] opc;
    useB = dutB;
    start = 1'b0;
    doReset(name);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (!done && n < maxInstr) begin
      word = prog[pcM];
      opc = word[15:11];
      checkState({name, "/fetch"}, 1, opc, pcM, cntM, 1'b0, 11'd0);
      start = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      checkState({name, "/decode"}, 2, opc, pcM, cntM, 1'b1, word[10:0]);
      start = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      checkState({name, "/exec"}, 3, opc, pcM, cntM, 1'b1, word[10:0]);
      start = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (cntM != 16'hFFFF) cntM++;
      n++;
      if (opc == 5'd0) done = 1'b1;
      else pcM = (pcM + 1) & mask;
    end
    if (done) begin
      word = prog[pcM];
      repeat (3) begin
        checkState({name, "/halt"}, 4, 5'd0, pcM, cntM, 1'b1, word[10:0]);
        start = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
  endtask

  // Reset asserted during the EXEC of a store must kill the strobe at once
  task automatic resetDuringStore();
    useB = 1'b0;
    start = 1'b0;
    prog[0] = {5'd1, 11'd9};
    doReset("rstSto");
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkState("rstSto/exec", 3, 5'd1, 0, 0, 1'b1, 11'd9);
    #2;
    reset = 1'b1;
    #1;
    checkState("rstSto/async", 0, 5'd0, 0, 0, 1'b1, 11'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkState("rstSto/after", 0, 5'd0, 0, 0, 1'b1, 11'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int len;
    logic [4:0] opc;
    reset = 1'b0;
    start = 1'b0;
    useB  = 1'b0;
    for (int i = 0; i < 2048; i++) prog[i] = {5'd3, 11'd0};

    // Basic program: LDI 5, ADDI 3, STO 7, HLT
    prog[0] = {5'd3, 11'd5};
    prog[1] = {5'd5, 11'd3};
    prog[2] = {5'd1, 11'd7};
    prog[3] = {5'd0, 11'd0};
    applyStimulus(1'b0, 11, 100, "basic");

    // Memory-operand SUB then HLT
    prog[0] = {5'd6, 11'd12};
    prog[1] = {5'd0, 11'd0};
    applyStimulus(1'b0, 11, 100, "subMem");

    // Undefined opcode executes as NOP
    prog[0] = {5'b10101, 11'h2AA};
    prog[1] = {5'd0, 11'd0};
    applyStimulus(1'b0, 11, 100, "undef");

    // Narrow PC: halt found at address 1
    for (int i = 0; i < 8; i++) prog[i] = {5'd3, 11'(i)};
    prog[1] = {5'd0, 11'd0};
    applyStimulus(1'b1, 3, 100, "narrowHlt");

    // Narrow PC with no HLT: PC must wrap from 7 to 0
    prog[1] = {5'd3, 11'd1};
    applyStimulus(1'b1, 3, 10, "narrowWrap");

    resetDuringStore();

    // Random programs, terminated by HLT
    for (int p = 0; p < 8; p++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        opc = 5'($urandom_range(0, 31));
        if (opc == 5'd0 && $urandom_range(0, 3) != 0) opc = 5'd4;
        prog[i] = {opc, 11'($urandom)};
      end
      prog[len] = {5'd0, 11'($urandom)};
      applyStimulus(1'b0, 11, 100, $sformatf("rand%0d", p));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
